// File: rtl/hsid_x_reg_cmd_master.sv
// Register-bus command master feeding hsid_x_ctrl_reg: queues host commands,
// issues one register transaction per command and returns one response each.

package hsid_x_ctrl_reg_pkg;

  parameter int BlockAw = 5;

  typedef enum logic [2:0] {
    HSID_X_CTRL_CONTROL       = 3'd0,
    HSID_X_CTRL_LIBRARY_SIZE  = 3'd1,
    HSID_X_CTRL_MSE_MIN_VALUE = 3'd2,
    HSID_X_CTRL_STATUS        = 3'd3,
    HSID_X_CTRL_THRESHOLD     = 3'd4
  } hsid_x_ctrl_id_e;

  parameter logic [BlockAw-1:0] HSID_X_CTRL_CONTROL_OFFSET       = 5'h00;
  parameter logic [BlockAw-1:0] HSID_X_CTRL_LIBRARY_SIZE_OFFSET  = 5'h04;
  parameter logic [BlockAw-1:0] HSID_X_CTRL_MSE_MIN_VALUE_OFFSET = 5'h08;
  parameter logic [BlockAw-1:0] HSID_X_CTRL_STATUS_OFFSET        = 5'h0c;
  parameter logic [BlockAw-1:0] HSID_X_CTRL_THRESHOLD_OFFSET     = 5'h10;

  // Byte-enable mask of the writable bytes of each register, indexed by id.
  parameter logic [3:0] HSID_X_CTRL_PERMIT [5] = '{
    4'b0001,
    4'b0011,
    4'b1111,
    4'b0001,
    4'b1111
  };

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

endpackage

module hsid_x_reg_cmd_master
  import hsid_x_ctrl_reg_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  hsid_x_ctrl_id_e cmd_ctrl_id_i,
  input  logic            cmd_write_i,
  input  logic [31:0]     cmd_wdata_i,
  output reg_req_t        reg_req_o,
  input  reg_rsp_t        reg_rsp_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output hsid_x_ctrl_id_e rsp_ctrl_id_o,
  output logic [31:0]     rsp_rdata_o,
  output logic            rsp_error_o,
  output logic            busy_o
);

  localparam int PtrW   = $clog2(FIFO_DEPTH);
  localparam int IdW    = $bits(hsid_x_ctrl_id_e);
  localparam int EntryW = IdW + 1 + 32;
  localparam int CntW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_e;

  function automatic logic [31:0] id_addr(input hsid_x_ctrl_id_e id);
    case (id)
      HSID_X_CTRL_CONTROL:       id_addr = 32'(HSID_X_CTRL_CONTROL_OFFSET);
      HSID_X_CTRL_LIBRARY_SIZE:  id_addr = 32'(HSID_X_CTRL_LIBRARY_SIZE_OFFSET);
      HSID_X_CTRL_MSE_MIN_VALUE: id_addr = 32'(HSID_X_CTRL_MSE_MIN_VALUE_OFFSET);
      HSID_X_CTRL_STATUS:        id_addr = 32'(HSID_X_CTRL_STATUS_OFFSET);
      HSID_X_CTRL_THRESHOLD:     id_addr = 32'(HSID_X_CTRL_THRESHOLD_OFFSET);
      default:                   id_addr = 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] id_permit(input hsid_x_ctrl_id_e id);
    case (id)
      HSID_X_CTRL_CONTROL:       id_permit = HSID_X_CTRL_PERMIT[0];
      HSID_X_CTRL_LIBRARY_SIZE:  id_permit = HSID_X_CTRL_PERMIT[1];
      HSID_X_CTRL_MSE_MIN_VALUE: id_permit = HSID_X_CTRL_PERMIT[2];
      HSID_X_CTRL_STATUS:        id_permit = HSID_X_CTRL_PERMIT[3];
      HSID_X_CTRL_THRESHOLD:     id_permit = HSID_X_CTRL_PERMIT[4];
      default:                   id_permit = 4'b0000;
    endcase
  endfunction

  logic [EntryW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PtrW:0]     wr_ptr_q;
  logic [PtrW:0]     rd_ptr_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [EntryW-1:0] head;
  hsid_x_ctrl_id_e   head_id;
  logic              head_write;
  logic [31:0]       head_wdata;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  reg_req_t          req_q, req_d;
  hsid_x_ctrl_id_e   cur_id_q, cur_id_d;
  logic              rsp_valid_q, rsp_valid_d;
  hsid_x_ctrl_id_e   rsp_id_q, rsp_id_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_error_q, rsp_error_d;

  // Full when the pointers differ only in the wrap bit; a same-cycle pop
  // does not make room for a push.
  assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign push       = cmd_valid_i && !fifo_full;

  assign head       = fifo_mem[rd_ptr_q[PtrW-1:0]];
  assign head_id    = hsid_x_ctrl_id_e'(head[EntryW-1 -: IdW]);
  assign head_write = head[32];
  assign head_wdata = head[31:0];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q[PtrW-1:0]] <= {cmd_ctrl_id_i, cmd_write_i, cmd_wdata_i};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      cur_id_q    <= hsid_x_ctrl_id_e'('0);
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= hsid_x_ctrl_id_e'('0);
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      cur_id_q    <= cur_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    cur_id_d    = cur_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    pop         = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          req_d.valid = 1'b1;
          req_d.write = head_write;
          req_d.addr  = id_addr(head_id);
          req_d.wdata = head_write ? head_wdata : 32'h0;
          req_d.wstrb = head_write ? id_permit(head_id) : 4'b0000;
          cur_id_d    = head_id;
          cnt_d       = '0;
          state_d     = REQ;
        end
      end

      // Slave ready is checked before the limit so a late ready still wins.
      REQ: begin
        if (reg_rsp_i.ready) begin
          req_d.valid = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_id_d    = cur_id_q;
          rsp_rdata_d = req_q.write ? 32'h0 : reg_rsp_i.rdata;
          rsp_error_d = reg_rsp_i.error;
          state_d     = RESP;
        end else if (cnt_q == CntLimit) begin
          req_d.valid = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_id_d    = cur_id_q;
          rsp_rdata_d = 32'h0;
          rsp_error_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready_o   = !fifo_full;
  assign reg_req_o     = req_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_ctrl_id_o = rsp_id_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_error_o   = rsp_error_q;
  assign busy_o        = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_hsid_x_reg_cmd_master.sv
// Directed bench for hsid_x_reg_cmd_master: register transactions, stalls,
// timeout, slave error, back-pressure ordering and mid-transaction reset.

module tb_hsid_x_reg_cmd_master;
  import hsid_x_ctrl_reg_pkg::*;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            cmd_valid;
  logic            cmd_ready_o;
  hsid_x_ctrl_id_e cmd_ctrl_id;
  logic            cmd_write;
  logic [31:0]     cmd_wdata;
  reg_req_t        reg_req;
  reg_rsp_t        reg_rsp;
  logic            rsp_valid_o;
  logic            rsp_ready;
  hsid_x_ctrl_id_e rsp_ctrl_id_o;
  logic [31:0]     rsp_rdata_o;
  logic            rsp_error_o;
  logic            busy_o;

  logic            auto_ready;
  logic            man_ready;
  logic [31:0]     man_rdata;
  logic            man_error;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  hsid_x_reg_cmd_master #(
    .FIFO_DEPTH    (4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_ctrl_id_i(cmd_ctrl_id),
    .cmd_write_i  (cmd_write),
    .cmd_wdata_i  (cmd_wdata),
    .reg_req_o    (reg_req),
    .reg_rsp_i    (reg_rsp),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready),
    .rsp_ctrl_id_o(rsp_ctrl_id_o),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_error_o  (rsp_error_o),
    .busy_o       (busy_o)
  );

  // Slave stand-in: either a zero-wait responder echoing the address into
  // rdata, or fully hand-driven ready/rdata.
  always_comb begin
    reg_rsp.ready = auto_ready ? reg_req.valid : man_ready;
    reg_rsp.rdata = auto_ready ? {16'hA5A5, reg_req.addr[15:0]} : man_rdata;
    reg_rsp.error = man_error;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input hsid_x_ctrl_id_e id, input logic wr,
                               input logic [31:0] wd);
    int waited = 0;
    cmd_ctrl_id = id;
    cmd_write   = wr;
    cmd_wdata   = wd;
    cmd_valid   = 1'b1;
    while (!cmd_ready_o && waited < 50) begin
      waited++;
      tick();
    end
    checkOutput("push_accept", 32'(cmd_ready_o), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic waitRsp(input string tag);
    int waited = 0;
    while (!rsp_valid_o && waited < 100) begin
      waited++;
      tick();
    end
    checkOutput(tag, 32'(rsp_valid_o), 32'd1);
  endtask

  task automatic ackRsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    hsid_x_ctrl_id_e bp_id    [6] = '{HSID_X_CTRL_CONTROL, HSID_X_CTRL_LIBRARY_SIZE,
                                      HSID_X_CTRL_MSE_MIN_VALUE, HSID_X_CTRL_STATUS,
                                      HSID_X_CTRL_THRESHOLD, HSID_X_CTRL_LIBRARY_SIZE};
    logic            bp_write [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0]     bp_rdata [6] = '{32'hA5A50000, 32'hA5A50004, 32'hA5A50008,
                                      32'hA5A5000C, 32'hA5A50010, 32'h0};
    int accepted;
    int got;
    int n;
    logic accept_now;

    rst_ni      = 1'b0;
    cmd_valid   = 1'b0;
    cmd_ctrl_id = HSID_X_CTRL_CONTROL;
    cmd_write   = 1'b0;
    cmd_wdata   = 32'h0;
    rsp_ready   = 1'b0;
    auto_ready  = 1'b0;
    man_ready   = 1'b0;
    man_rdata   = 32'h0;
    man_error   = 1'b0;
    tick();
    tick();

    // Reset state
    checkOutput("rst_req_valid", 32'(reg_req.valid), 32'd0);
    checkOutput("rst_req_addr", reg_req.addr, 32'h0);
    checkOutput("rst_req_wdata", reg_req.wdata, 32'h0);
    checkOutput("rst_req_wr_strb", 32'({reg_req.write, reg_req.wstrb}), 32'h0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("rst_rsp_fields", {rsp_rdata_o[30:0], rsp_error_o}, 32'h0);
    checkOutput("rst_rsp_id", 32'(rsp_ctrl_id_o), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    rst_ni = 1'b1;
    tick();

    // 1: write LIBRARY_SIZE, slave ready in the first REQ cycle
    applyStimulus(HSID_X_CTRL_LIBRARY_SIZE, 1'b1, 32'h20);
    checkOutput("t1_valid_lat", 32'(reg_req.valid), 32'd0);
    checkOutput("t1_busy", 32'(busy_o), 32'd1);
    tick();
    checkOutput("t1_valid", 32'(reg_req.valid), 32'd1);
    checkOutput("t1_addr", reg_req.addr, 32'h4);
    checkOutput("t1_wstrb", 32'(reg_req.wstrb), 32'h3);
    checkOutput("t1_wdata", reg_req.wdata, 32'h20);
    checkOutput("t1_write", 32'(reg_req.write), 32'd1);
    man_ready = 1'b1;
    tick();
    man_ready = 1'b0;
    checkOutput("t1_valid_drop", 32'(reg_req.valid), 32'd0);
    checkOutput("t1_rsp_valid", 32'(rsp_valid_o), 32'd1);
    checkOutput("t1_rsp_error", 32'(rsp_error_o), 32'd0);
    checkOutput("t1_rsp_rdata", rsp_rdata_o, 32'h0);
    checkOutput("t1_rsp_id", 32'(rsp_ctrl_id_o), 32'd1);
    tick();
    checkOutput("t1_rsp_hold", 32'(rsp_valid_o), 32'd1);
    ackRsp();
    checkOutput("t1_rsp_clear", 32'(rsp_valid_o), 32'd0);
    checkOutput("t1_idle", 32'(busy_o), 32'd0);

    // 2: read MSE_MIN_VALUE, 3 wait cycles then rdata 0x1234
    applyStimulus(HSID_X_CTRL_MSE_MIN_VALUE, 1'b0, 32'hFFFF_FFFF);
    tick();
    checkOutput("t2_addr", reg_req.addr, 32'h8);
    checkOutput("t2_wstrb_wdata", reg_req.wdata | 32'(reg_req.wstrb), 32'h0);
    checkOutput("t2_write", 32'(reg_req.write), 32'd0);
    tick();
    tick();
    tick();
    checkOutput("t2_valid_held", 32'(reg_req.valid), 32'd1);
    man_ready = 1'b1;
    man_rdata = 32'h1234;
    tick();
    man_ready = 1'b0;
    checkOutput("t2_valid_drop", 32'(reg_req.valid), 32'd0);
    checkOutput("t2_rsp_rdata", rsp_rdata_o, 32'h1234);
    checkOutput("t2_rsp_id", 32'(rsp_ctrl_id_o), 32'd2);
    checkOutput("t2_rsp_error", 32'(rsp_error_o), 32'd0);
    ackRsp();

    // 5: slave error on a write to STATUS
    applyStimulus(HSID_X_CTRL_STATUS, 1'b1, 32'hAB);
    tick();
    checkOutput("t5_addr", reg_req.addr, 32'hC);
    checkOutput("t5_wstrb", 32'(reg_req.wstrb), 32'h1);
    man_ready = 1'b1;
    man_error = 1'b1;
    man_rdata = 32'hDEAD;
    tick();
    man_ready = 1'b0;
    man_error = 1'b0;
    checkOutput("t5_rsp_error", 32'(rsp_error_o), 32'd1);
    checkOutput("t5_rsp_rdata", rsp_rdata_o, 32'h0);
    checkOutput("t5_rsp_id", 32'(rsp_ctrl_id_o), 32'd3);
    ackRsp();
    checkOutput("t5_idle", 32'(busy_o), 32'd0);

    // 4: timeout, slave never ready
    man_rdata = 32'hDEAD_BEEF;
    applyStimulus(HSID_X_CTRL_THRESHOLD, 1'b0, 32'h0);
    tick();
    n = 0;
    while (reg_req.valid && n < 40) begin
      n++;
      tick();
    end
    checkOutput("t4_valid_cycles", 32'(n), 32'd16);
    checkOutput("t4_rsp_valid", 32'(rsp_valid_o), 32'd1);
    checkOutput("t4_rsp_error", 32'(rsp_error_o), 32'd1);
    checkOutput("t4_rsp_rdata", rsp_rdata_o, 32'h0);
    checkOutput("t4_rsp_id", 32'(rsp_ctrl_id_o), 32'd4);
    ackRsp();
    auto_ready = 1'b1;
    applyStimulus(HSID_X_CTRL_CONTROL, 1'b1, 32'h7);
    waitRsp("t4_next_rsp");
    checkOutput("t4_next_error", 32'(rsp_error_o), 32'd0);
    checkOutput("t4_next_id", 32'(rsp_ctrl_id_o), 32'd0);
    ackRsp();
    auto_ready = 1'b0;

    // Ready arriving in the 16th cycle wins over the timeout
    applyStimulus(HSID_X_CTRL_MSE_MIN_VALUE, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 15; i++) tick();
    checkOutput("lim_valid_16", 32'(reg_req.valid), 32'd1);
    man_ready = 1'b1;
    man_rdata = 32'h55;
    tick();
    man_ready = 1'b0;
    checkOutput("lim_rsp_error", 32'(rsp_error_o), 32'd0);
    checkOutput("lim_rsp_rdata", rsp_rdata_o, 32'h55);
    ackRsp();

    // 3: back-pressure, six commands with responses held off
    auto_ready = 1'b1;
    accepted   = 0;
    for (int i = 0; i < 6; i++) begin
      cmd_ctrl_id = bp_id[i];
      cmd_write   = bp_write[i];
      cmd_wdata   = 32'h100 + 32'(i);
      cmd_valid   = 1'b1;
      if (i < 5) begin
        if (cmd_ready_o) accepted++;
        tick();
      end
    end
    checkOutput("t3_accepted", 32'(accepted), 32'd5);
    checkOutput("t3_cmd_ready_low", 32'(cmd_ready_o), 32'd0);
    tick();
    checkOutput("t3_still_full", 32'(cmd_ready_o), 32'd0);
    rsp_ready = 1'b1;
    got = 0;
    n   = 0;
    while (got < 6 && n < 200) begin
      n++;
      if (rsp_valid_o) begin
        checkOutput($sformatf("t3_id%0d", got), 32'(rsp_ctrl_id_o), 32'(bp_id[got]));
        checkOutput($sformatf("t3_rdata%0d", got), rsp_rdata_o, bp_rdata[got]);
        got++;
      end
      accept_now = cmd_valid && cmd_ready_o;
      tick();
      if (accept_now) cmd_valid = 1'b0;
    end
    checkOutput("t3_rsp_count", 32'(got), 32'd6);
    rsp_ready  = 1'b0;
    auto_ready = 1'b0;
    tick();
    checkOutput("t3_idle", 32'(busy_o), 32'd0);

    // 6: reset mid-REQ with two commands queued
    applyStimulus(HSID_X_CTRL_CONTROL, 1'b1, 32'h1);
    applyStimulus(HSID_X_CTRL_STATUS, 1'b1, 32'h2);
    applyStimulus(HSID_X_CTRL_THRESHOLD, 1'b1, 32'h3);
    checkOutput("t6_in_req", 32'(reg_req.valid), 32'd1);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    checkOutput("t6_valid_drop", 32'(reg_req.valid), 32'd0);
    checkOutput("t6_busy", 32'(busy_o), 32'd0);
    checkOutput("t6_cmd_ready", 32'(cmd_ready_o), 32'd1);
    tick();
    tick();
    checkOutput("t6_no_rsp", 32'(rsp_valid_o), 32'd0);
    checkOutput("t6_no_req", 32'(reg_req.valid), 32'd0);
    auto_ready = 1'b1;
    applyStimulus(HSID_X_CTRL_LIBRARY_SIZE, 1'b1, 32'h9);
    waitRsp("t6_new_rsp");
    checkOutput("t6_new_id", 32'(rsp_ctrl_id_o), 32'd1);
    checkOutput("t6_new_error", 32'(rsp_error_o), 32'd0);
    ackRsp();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
